// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx -- 8N1 UART receiver with a one-entry valid/ready output register.
//
// The line is brought into the clk_i domain by a two-flop synchronizer. Bytes
// are recovered by mid-bit sampling with a single baud counter. A start bit is
// re-checked at its midpoint so short glitches are ignored. A low stop bit is a
// framing error. After a framing error the receiver waits for the line to go
// high again, so a held-low (break) line is not read as a run of 0x00 bytes.
//
// Ports:
//   clk_i        in   1  system clock
//   rstn_i       in   1  asynchronous active-low reset
//   uart_rx_i    in   1  serial line, asynchronous, idle high
//   data_o       out  8  received byte, meaningful while valid_o=1
//   valid_o      out  1  a byte is held in the output register
//   ready_i      in   1  consumer takes data_o when valid_o & ready_i
//   frame_err_o  out  1  one-cycle pulse: stop bit sampled low
//   overrun_o    out  1  one-cycle pulse: finished byte dropped, register full
//
// Parameters:
//   FREQ  system clock frequency in Hz
//   BAUD  line rate in bit/s (FREQ/BAUD must be at least 4)
// -----------------------------------------------------------------------------
module uart_rx #(
  parameter int FREQ = 27000000,
  parameter int BAUD = 115200
) (
  input  logic       clk_i,
  input  logic       rstn_i,
  input  logic       uart_rx_i,
  output logic [7:0] data_o,
  output logic       valid_o,
  input  logic       ready_i,
  output logic       frame_err_o,
  output logic       overrun_o
);

  localparam int CLKS_PER_BIT = FREQ / BAUD;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CNT_W        = 25;

  localparam logic [CNT_W-1:0] CNT_BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF_END = CNT_W'(HALF_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  logic             rx_meta_p0;
  logic             rx_s;

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [2:0]       bit_idx_q;
  logic [2:0]       bit_idx_d;
  logic [7:0]       shreg_q;
  logic [7:0]       shreg_d;
  logic             commit;
  logic             ferr_set;

  // Stage p0/p1: two-flop synchronizer, idle-high reset value
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      rx_meta_p0 <= 1'b1;
      rx_s       <= 1'b1;
    end else begin
      rx_meta_p0 <= uart_rx_i;
      rx_s       <= rx_meta_p0;
    end
  end

  // Receiver state, baud counter, bit index and shift register
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shreg_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shreg_q   <= shreg_d;
    end
  end

  // Next-state logic. The counter only runs inside START/DATA/STOP; it is held
  // at zero in IDLE and BREAK so every timed state is entered with cnt=0.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + 1'b1;
    bit_idx_d = bit_idx_q;
    shreg_d   = shreg_q;
    commit    = 1'b0;
    ferr_set  = 1'b0;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!rx_s) begin
          state_d = S_START;
        end
      end

      S_START: begin
        if (cnt_q == CNT_HALF_END) begin
          cnt_d = '0;
          // Line back high at mid start bit: a glitch, silently dropped.
          if (rx_s) begin
            state_d = S_IDLE;
          end else begin
            state_d   = S_DATA;
            bit_idx_d = '0;
          end
        end
      end

      S_DATA: begin
        if (cnt_q == CNT_BIT_END) begin
          cnt_d   = '0;
          // LSB arrives first, so shift right and insert at the top.
          shreg_d = {rx_s, shreg_q[7:1]};
          if (bit_idx_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end

      S_STOP: begin
        if (cnt_q == CNT_BIT_END) begin
          cnt_d = '0;
          if (rx_s) begin
            commit  = 1'b1;
            state_d = S_IDLE;
          end else begin
            ferr_set = 1'b1;
            state_d  = S_BREAK;
          end
        end
      end

      S_BREAK: begin
        cnt_d = '0;
        if (rx_s) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Output register and error pulses. A commit while the register is full is
  // accepted only if the consumer takes the old byte in that same cycle.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      data_o      <= '0;
      valid_o     <= 1'b0;
      frame_err_o <= 1'b0;
      overrun_o   <= 1'b0;
    end else begin
      frame_err_o <= ferr_set;
      overrun_o   <= commit & valid_o & ~ready_i;
      if (commit) begin
        if (!valid_o || ready_i) begin
          data_o  <= shreg_q;
          valid_o <= 1'b1;
        end
      end else if (valid_o && ready_i) begin
        valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx -- self-checking bench for uart_rx.
//
// dut  : FREQ=1152000, BAUD=115200 (10 clocks per bit) for directed cases.
// dut2 : default FREQ/BAUD, fed by a behavioural transmitter for loopback.
// Expected bytes come from the frames the bench itself builds; accepted
// bytes are collected at each valid/ready handshake and compared at the end.
// -----------------------------------------------------------------------------
module tb_uart_rx;

  localparam int CPB  = 10;
  localparam int LAT  = (19 * CPB) / 2 + 3;   // falling start edge -> valid_o
  localparam int CPB2 = 27000000 / 115200;

  logic       clk;
  logic       rstn;
  logic       rx;
  logic       rx2;
  logic       ready;
  logic       ready2;
  logic [7:0] data_o;
  logic       valid_o;
  logic       frame_err_o;
  logic       overrun_o;
  logic [7:0] data2;
  logic       valid2;
  logic       ferr2;
  logic       ovr2;

  int total;
  int bad;

  int cyc = 0;
  int fall_cyc = 0;
  int rise_cyc = 0;
  int ferr_n = 0;
  int ovr_n = 0;
  int both_n = 0;
  int vrise_n = 0;
  int ferr2_n = 0;
  int ovr2_n = 0;
  logic vprev = 1'b0;

  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  logic [7:0] exp2_q[$];
  logic [7:0] got2_q[$];

  uart_rx #(.FREQ(1152000), .BAUD(115200)) dut (
    .clk_i       (clk),
    .rstn_i      (rstn),
    .uart_rx_i   (rx),
    .data_o      (data_o),
    .valid_o     (valid_o),
    .ready_i     (ready),
    .frame_err_o (frame_err_o),
    .overrun_o   (overrun_o)
  );

  uart_rx dut2 (
    .clk_i       (clk),
    .rstn_i      (rstn),
    .uart_rx_i   (rx2),
    .data_o      (data2),
    .valid_o     (valid2),
    .ready_i     (ready2),
    .frame_err_o (ferr2),
    .overrun_o   (ovr2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Event monitors, sampled away from the active edge
  always @(negedge clk) begin
    ferr_n  <= ferr_n + int'(frame_err_o);
    ovr_n   <= ovr_n + int'(overrun_o);
    both_n  <= both_n + int'(frame_err_o & overrun_o);
    ferr2_n <= ferr2_n + int'(ferr2);
    ovr2_n  <= ovr2_n + int'(ovr2);
    vprev   <= valid_o;
    if (valid_o && !vprev) begin
      vrise_n  <= vrise_n + 1;
      rise_cyc <= cyc;
    end
    if (valid_o && ready) got_q.push_back(data_o);
    if (valid2 && ready2) got2_q.push_back(data2);
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, expv);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One 8N1 frame: start 0, data LSB first, then the given stop level.
  // rdy_at >= 0 raises ready for exactly that tick of the frame.
  task automatic send_frame(input logic [7:0] b, input logic stop, input int cpb,
                            input bit on2, input int rdy_at);
    logic [9:0] fr;
    fr = {stop, b, 1'b0};
    for (int t = 0; t < 10 * cpb; t++) begin
      if (on2) rx2 = fr[t / cpb];
      else     rx  = fr[t / cpb];
      if (t == 0) fall_cyc = cyc;
      if (rdy_at >= 0) ready = (t == rdy_at);
      tick(1);
    end
    if (rdy_at >= 0) ready = 1'b0;
  endtask

  task automatic consume();
    ready = 1'b1;
    tick(1);
    ready = 1'b0;
  endtask

  initial begin
    int v0;
    int f0;
    int o0;
    int n;
    logic [7:0] b;
    logic [7:0] fr;

    total = 0;
    bad = 0;
    rstn = 1'b0;
    rx = 1'b1;
    rx2 = 1'b1;
    ready = 1'b0;
    ready2 = 1'b1;
    tick(3);

    chk("rst_data", data_o, 8'h00);
    chk("rst_valid", valid_o, 1'b0);
    chk("rst_ferr", frame_err_o, 1'b0);
    chk("rst_ovr", overrun_o, 1'b0);
    rstn = 1'b1;
    tick(3);

    // Single byte, held until consumed
    send_frame(8'hA5, 1'b1, CPB, 1'b0, -1);
    tick(3);
    chk("lat_a5", rise_cyc - fall_cyc, LAT);
    chk("valid_a5", valid_o, 1'b1);
    chk("data_a5", data_o, 8'hA5);
    chk("ferr_a5", ferr_n, 0);
    chk("ovr_a5", ovr_n, 0);
    exp_q.push_back(8'hA5);
    consume();
    @(negedge clk);
    chk("valid_after_hs", valid_o, 1'b0);
    tick(1);

    // Short low glitch must not produce a byte or an error
    v0 = vrise_n;
    f0 = ferr_n;
    rx = 1'b0;
    tick(3);
    rx = 1'b1;
    tick(20);
    chk("glitch_valid", valid_o, 1'b0);
    chk("glitch_vrise", vrise_n - v0, 0);
    chk("glitch_ferr", ferr_n - f0, 0);
    b = 8'($urandom_range(0, 255));
    send_frame(b, 1'b1, CPB, 1'b0, -1);
    tick(3);
    chk("after_glitch_data", data_o, b);
    exp_q.push_back(b);
    consume();

    // Framing error followed by a held-low line, then a clean frame
    f0 = ferr_n;
    v0 = vrise_n;
    send_frame(8'h3C, 1'b0, CPB, 1'b0, -1);
    rx = 1'b0;
    tick(30);
    rx = 1'b1;
    tick(5);
    chk("ferr_pulse", ferr_n - f0, 1);
    chk("ferr_valid", valid_o, 1'b0);
    send_frame(8'h55, 1'b1, CPB, 1'b0, -1);
    tick(3);
    chk("data_55", data_o, 8'h55);
    chk("bytes_after_break", vrise_n - v0, 1);
    chk("ferr_still_one", ferr_n - f0, 1);
    exp_q.push_back(8'h55);
    consume();

    // Overrun: second byte dropped while the first is unread
    o0 = ovr_n;
    send_frame(8'h11, 1'b1, CPB, 1'b0, -1);
    send_frame(8'h22, 1'b1, CPB, 1'b0, -1);
    tick(3);
    chk("ovr_data", data_o, 8'h11);
    chk("ovr_valid", valid_o, 1'b1);
    chk("ovr_pulse", ovr_n - o0, 1);
    exp_q.push_back(8'h11);
    consume();

    // Same pair, consumer takes the old byte in the commit cycle
    send_frame(8'h11, 1'b1, CPB, 1'b0, -1);
    send_frame(8'h22, 1'b1, CPB, 1'b0, LAT - 1);
    tick(3);
    chk("hs_commit_data", data_o, 8'h22);
    chk("hs_commit_valid", valid_o, 1'b1);
    chk("hs_commit_no_ovr", ovr_n - o0, 1);
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h22);
    consume();

    // Reset in the middle of 0xF0 with an unread byte pending
    b = 8'($urandom_range(0, 255));
    send_frame(b, 1'b1, CPB, 1'b0, -1);
    tick(3);
    fr = 8'hF0;
    rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 4; i++) begin
      rx = fr[i];
      tick(CPB);
    end
    rstn = 1'b0;
    #2;
    chk("amid_rst_valid", valid_o, 1'b0);
    chk("amid_rst_data", data_o, 8'h00);
    chk("amid_rst_ferr", frame_err_o, 1'b0);
    chk("amid_rst_ovr", overrun_o, 1'b0);
    rx = 1'b1;
    tick(2);
    rstn = 1'b1;
    tick(3);
    send_frame(8'h81, 1'b1, CPB, 1'b0, -1);
    tick(3);
    chk("data_81", data_o, 8'h81);
    exp_q.push_back(8'h81);
    consume();

    // Random byte stream with random idle gaps
    for (int k = 0; k < 8; k++) begin
      b = 8'($urandom_range(0, 255));
      n = int'($urandom_range(0, 4));
      tick(n);
      send_frame(b, 1'b1, CPB, 1'b0, -1);
      tick(1);
      chk("rand_data", data_o, b);
      exp_q.push_back(b);
      consume();
    end

    // Loopback at default FREQ/BAUD with a consumer that is always ready
    exp2_q.push_back(8'h00);
    exp2_q.push_back(8'hFF);
    exp2_q.push_back(8'h5A);
    foreach (exp2_q[i]) send_frame(exp2_q[i], 1'b1, CPB2, 1'b1, -1);
    tick(5);
    chk("lb_ferr", ferr2_n, 0);
    chk("lb_ovr", ovr2_n, 0);

    // Scoreboards
    chk("sb_count", got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk("sb_byte", got_q[i], exp_q[i]);
    chk("lb_count", got2_q.size(), exp2_q.size());
    for (int i = 0; i < exp2_q.size() && i < got2_q.size(); i++)
      chk("lb_byte", got2_q[i], exp2_q[i]);
    chk("never_both", both_n, 0);
    chk("ferr_total", ferr_n, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
